hdlc_rx_frame_ctrl: RTL and testbench

Frame-level sequencer for the HDLC receive channel. It consumes flag, abort and byte-ready events from the Rx bit-level front end (flag detector, zero-bit remover, byte shifter) and generates the frame-qualifying signals Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal and Rx_Overflow. It also produces end-of-frame status for the register interface. It sits between the Rx front end and the Rx frame buffer / status register.

---
 rtl/hdlc_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_hdlc_rx_frame_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_frame_ctrl.sv
// hdlc_rx_frame_ctrl
// Frame-level sequencer for the HDLC receive channel. Turns flag, abort and
// byte strobes from the bit-level front end into buffer writes and
// end-of-frame status. Every output is registered, so each response shows
// up one cycle after the strobe that causes it.

module hdlc_rx_frame_ctrl #(
   parameter int MAX_BYTES = 128,
   parameter int FCS_BYTES = 2,
   parameter int CNT_W     = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             RxEN,
   input  logic             Rx_FlagDetect,
   input  logic             Rx_AbortDetect,
   input  logic             Rx_NewByte,
   input  logic [7:0]       Rx_Data,
   input  logic             Rx_FCSerr,
   input  logic             Rx_ReadDone,
   input  logic             Rx_Drop,
   output logic             Rx_ValidFrame,
   output logic             Rx_WrBuff,
   output logic [7:0]       Rx_DataBuff,
   output logic             Rx_AbortSignal,
   output logic             Rx_Overflow,
   output logic             Rx_EoF,
   output logic             Rx_Ready,
   output logic             Rx_FrameError,
   output logic [CNT_W-1:0] Rx_FrameSize
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
   localparam logic [CNT_W-1:0] FCS_CNT = CNT_W'(FCS_BYTES);

   // IDLE: hunting for a flag; OPEN: between frames after a flag;
   // RCV: collecting bytes; DONE: a closed frame is held for software.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      RCV  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q,        state_d;
   logic [CNT_W-1:0] count_q,        count_d;
   logic             valid_frame_q,  valid_frame_d;
   logic             wr_buff_q,      wr_buff_d;
   logic [7:0]       data_buff_q,    data_buff_d;
   logic             abort_signal_q, abort_signal_d;
   logic             overflow_q,     overflow_d;
   logic             eof_q,          eof_d;
   logic             ready_q,        ready_d;
   logic             frame_error_q,  frame_error_d;
   logic [CNT_W-1:0] frame_size_q,   frame_size_d;

   logic             runt;
   logic             room_left;

   // Frame-length qualifiers derived from the current byte count.
   always_comb begin
      runt      = (count_q <= FCS_CNT);
      room_left = (count_q < MAX_CNT);
   end

   // Next-state and next-output logic; strobes are resolved in priority
   // order disable > drop > abort > flag > byte, lower ones discarded.
   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      valid_frame_d  = valid_frame_q;
      wr_buff_d      = 1'b0;
      data_buff_d    = data_buff_q;
      abort_signal_d = 1'b0;
      overflow_d     = overflow_q;
      eof_d          = 1'b0;
      ready_d        = ready_q;
      frame_error_d  = frame_error_q;
      frame_size_d   = frame_size_q;

      if (!RxEN && (state_q != DONE)) begin
         // A held frame survives disable; anything in flight is dropped.
         state_d       = IDLE;
         valid_frame_d = 1'b0;
         count_d       = '0;
         overflow_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (!Rx_Drop && !Rx_AbortDetect && Rx_FlagDetect) begin
                  state_d = OPEN;
               end
            end

            OPEN: begin
               if (Rx_Drop || Rx_AbortDetect) begin
                  state_d = IDLE;
               end else if (Rx_FlagDetect) begin
                  state_d = OPEN;
               end else if (Rx_NewByte) begin
                  state_d       = RCV;
                  valid_frame_d = 1'b1;
                  wr_buff_d     = 1'b1;
                  data_buff_d   = Rx_Data;
                  count_d       = CNT_W'(1);
               end
            end

            RCV: begin
               if (Rx_Drop) begin
                  state_d       = IDLE;
                  valid_frame_d = 1'b0;
                  count_d       = '0;
                  overflow_d    = 1'b0;
               end else if (Rx_AbortDetect) begin
                  state_d        = IDLE;
                  valid_frame_d  = 1'b0;
                  abort_signal_d = 1'b1;
                  count_d        = '0;
                  overflow_d     = 1'b0;
               end else if (Rx_FlagDetect) begin
                  state_d       = DONE;
                  valid_frame_d = 1'b0;
                  eof_d         = 1'b1;
                  ready_d       = 1'b1;
                  frame_error_d = Rx_FCSerr | runt;
                  frame_size_d  = runt ? '0 : (count_q - FCS_CNT);
               end else if (Rx_NewByte) begin
                  if (room_left) begin
                     wr_buff_d   = 1'b1;
                     data_buff_d = Rx_Data;
                     count_d     = count_q + CNT_W'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
            end

            DONE: begin
               if (Rx_Drop || Rx_ReadDone) begin
                  state_d       = IDLE;
                  ready_d       = 1'b0;
                  frame_error_d = 1'b0;
                  overflow_d    = 1'b0;
                  frame_size_d  = '0;
                  count_d       = '0;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q        <= IDLE;
         count_q        <= '0;
         valid_frame_q  <= 1'b0;
         wr_buff_q      <= 1'b0;
         data_buff_q    <= '0;
         abort_signal_q <= 1'b0;
         overflow_q     <= 1'b0;
         eof_q          <= 1'b0;
         ready_q        <= 1'b0;
         frame_error_q  <= 1'b0;
         frame_size_q   <= '0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         valid_frame_q  <= valid_frame_d;
         wr_buff_q      <= wr_buff_d;
         data_buff_q    <= data_buff_d;
         abort_signal_q <= abort_signal_d;
         overflow_q     <= overflow_d;
         eof_q          <= eof_d;
         ready_q        <= ready_d;
         frame_error_q  <= frame_error_d;
         frame_size_q   <= frame_size_d;
      end
   end

   // Registered outputs drive the ports directly.
   always_comb begin
      Rx_ValidFrame  = valid_frame_q;
      Rx_WrBuff      = wr_buff_q;
      Rx_DataBuff    = data_buff_q;
      Rx_AbortSignal = abort_signal_q;
      Rx_Overflow    = overflow_q;
      Rx_EoF         = eof_q;
      Rx_Ready       = ready_q;
      Rx_FrameError  = frame_error_q;
      Rx_FrameSize   = frame_size_q;
   end

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// tb_hdlc_rx_frame_ctrl
// Directed bench for the HDLC receive frame sequencer. Each stimulus step
// pushes the hand-computed output record it should cause into a queue; a
// monitor pops a record whenever the DUT shows any activity and compares.

module tb_hdlc_rx_frame_ctrl;

   logic       Clk;
   logic       Rst;
   logic       RxEN;
   logic       Rx_FlagDetect;
   logic       Rx_AbortDetect;
   logic       Rx_NewByte;
   logic [7:0] Rx_Data;
   logic       Rx_FCSerr;
   logic       Rx_ReadDone;
   logic       Rx_Drop;
   logic       Rx_ValidFrame;
   logic       Rx_WrBuff;
   logic [7:0] Rx_DataBuff;
   logic       Rx_AbortSignal;
   logic       Rx_Overflow;
   logic       Rx_EoF;
   logic       Rx_Ready;
   logic       Rx_FrameError;
   logic [7:0] Rx_FrameSize;

   typedef struct {
      int         cyc;
      logic       valid;
      logic       wr;
      logic [7:0] data;
      logic       abort;
      logic       ovf;
      logic       eof;
      logic       ready;
      logic       err;
      logic [7:0] size;
   } rec_t;

   rec_t expQ[$];
   int   cycleCount = 0;
   int   numChecks  = 0;
   int   numFails   = 0;
   logic monitorOn  = 1'b0;
   logic prevValid  = 1'b0;
   logic prevReady  = 1'b0;
   logic prevOvf    = 1'b0;

   hdlc_rx_frame_ctrl #(
      .MAX_BYTES(128),
      .FCS_BYTES(2),
      .CNT_W(8)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .RxEN(RxEN),
      .Rx_FlagDetect(Rx_FlagDetect),
      .Rx_AbortDetect(Rx_AbortDetect),
      .Rx_NewByte(Rx_NewByte),
      .Rx_Data(Rx_Data),
      .Rx_FCSerr(Rx_FCSerr),
      .Rx_ReadDone(Rx_ReadDone),
      .Rx_Drop(Rx_Drop),
      .Rx_ValidFrame(Rx_ValidFrame),
      .Rx_WrBuff(Rx_WrBuff),
      .Rx_DataBuff(Rx_DataBuff),
      .Rx_AbortSignal(Rx_AbortSignal),
      .Rx_Overflow(Rx_Overflow),
      .Rx_EoF(Rx_EoF),
      .Rx_Ready(Rx_Ready),
      .Rx_FrameError(Rx_FrameError),
      .Rx_FrameSize(Rx_FrameSize)
   );

   // Free-running 10 ns clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Cycle index used to time-stamp expected and observed records.
   always @(posedge Clk) cycleCount <= cycleCount + 1;

   // Backstop so a stuck run still ends with a report.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached with %0d records pending", expQ.size());
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   task automatic expectEvent(input logic valid, input logic wr, input logic [7:0] data,
                              input logic abort, input logic ovf, input logic eof,
                              input logic ready, input logic err, input logic [7:0] size);
      rec_t r;
      r.cyc   = cycleCount + 1;
      r.valid = valid;
      r.wr    = wr;
      r.data  = data;
      r.abort = abort;
      r.ovf   = ovf;
      r.eof   = eof;
      r.ready = ready;
      r.err   = err;
      r.size  = size;
      expQ.push_back(r);
   endtask

   task automatic expectWr(input logic [7:0] data);
      expectEvent(1'b1, 1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic applyStimulus(input logic flag, input logic abort, input logic newByte,
                                input logic [7:0] data, input logic fcsErr,
                                input logic readDone, input logic drop);
      Rx_FlagDetect  = flag;
      Rx_AbortDetect = abort;
      Rx_NewByte     = newByte;
      Rx_Data        = data;
      Rx_FCSerr      = fcsErr;
      Rx_ReadDone    = readDone;
      Rx_Drop        = drop;
      tick();
      Rx_FlagDetect  = 1'b0;
      Rx_AbortDetect = 1'b0;
      Rx_NewByte     = 1'b0;
      Rx_FCSerr      = 1'b0;
      Rx_ReadDone    = 1'b0;
      Rx_Drop        = 1'b0;
   endtask

   task automatic sendFlag(input logic fcsErr);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, fcsErr, 1'b0, 1'b0);
   endtask

   task automatic sendByte(input logic [7:0] data);
      applyStimulus(1'b0, 1'b0, 1'b1, data, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic sendAbort();
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic sendReadDone();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic sendDrop();
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   // Monitor: any pulse or level change on the status outputs must match
   // the next queued record, including the cycle in which it appears.
   always @(negedge Clk) begin
      rec_t r;
      logic activity;
      if (monitorOn) begin
         if (Rx_WrBuff !== 1'b0) checkOutput("wr_implies_valid", {31'd0, Rx_ValidFrame}, 32'd1);
         activity = (Rx_WrBuff !== 1'b0) || (Rx_EoF !== 1'b0) || (Rx_AbortSignal !== 1'b0) ||
                    (Rx_ValidFrame !== prevValid) || (Rx_Ready !== prevReady) ||
                    (Rx_Overflow !== prevOvf);
         if (activity) begin
            if (expQ.size() == 0) begin
               numChecks++;
               numFails++;
               $display("[TB] FAIL unexpected_event: cycle %0d valid=%b wr=%b abort=%b ovf=%b eof=%b ready=%b, required no activity",
                        cycleCount, Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow, Rx_EoF, Rx_Ready);
            end else begin
               r = expQ.pop_front();
               checkOutput("event_cycle", cycleCount, r.cyc);
               checkOutput("valid_frame", {31'd0, Rx_ValidFrame}, {31'd0, r.valid});
               checkOutput("wr_buff", {31'd0, Rx_WrBuff}, {31'd0, r.wr});
               if (r.wr) checkOutput("data_buff", {24'd0, Rx_DataBuff}, {24'd0, r.data});
               checkOutput("abort_signal", {31'd0, Rx_AbortSignal}, {31'd0, r.abort});
               checkOutput("overflow", {31'd0, Rx_Overflow}, {31'd0, r.ovf});
               checkOutput("eof", {31'd0, Rx_EoF}, {31'd0, r.eof});
               checkOutput("ready", {31'd0, Rx_Ready}, {31'd0, r.ready});
               checkOutput("frame_error", {31'd0, Rx_FrameError}, {31'd0, r.err});
               checkOutput("frame_size", {24'd0, Rx_FrameSize}, {24'd0, r.size});
            end
         end
      end
      prevValid = Rx_ValidFrame;
      prevReady = Rx_Ready;
      prevOvf   = Rx_Overflow;
   end

   // Directed test sequence.
   initial begin
      Rst            = 1'b1;
      RxEN           = 1'b1;
      Rx_FlagDetect  = 1'b0;
      Rx_AbortDetect = 1'b0;
      Rx_NewByte     = 1'b0;
      Rx_Data        = 8'h00;
      Rx_FCSerr      = 1'b0;
      Rx_ReadDone    = 1'b0;
      Rx_Drop        = 1'b0;
      tick();
      tick();
      Rst = 1'b0;

      // Reset state
      checkOutput("rst_valid", {31'd0, Rx_ValidFrame}, 32'd0);
      checkOutput("rst_wr", {31'd0, Rx_WrBuff}, 32'd0);
      checkOutput("rst_data", {24'd0, Rx_DataBuff}, 32'd0);
      checkOutput("rst_abort", {31'd0, Rx_AbortSignal}, 32'd0);
      checkOutput("rst_ovf", {31'd0, Rx_Overflow}, 32'd0);
      checkOutput("rst_eof", {31'd0, Rx_EoF}, 32'd0);
      checkOutput("rst_ready", {31'd0, Rx_Ready}, 32'd0);
      checkOutput("rst_err", {31'd0, Rx_FrameError}, 32'd0);
      checkOutput("rst_size", {24'd0, Rx_FrameSize}, 32'd0);
      monitorOn = 1'b1;
      tick();

      // 1: six-byte good frame, strobes ignored while held, then read out
      $display("[TB] test 1: good 6-byte frame");
      sendFlag(1'b0);
      for (int i = 1; i <= 6; i++) begin
         expectWr(8'(i * 17));
         sendByte(8'(i * 17));
      end
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4);
      sendFlag(1'b0);
      tick();
      sendFlag(1'b0);
      sendByte(8'hEE);
      sendAbort();
      tick();
      checkOutput("t1_ready_held", {31'd0, Rx_Ready}, 32'd1);
      checkOutput("t1_size_held", {24'd0, Rx_FrameSize}, 32'd4);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      sendReadDone();
      tick();

      // 2: aborted frame; ReadDone outside DONE has no effect
      $display("[TB] test 2: abort mid-frame");
      sendFlag(1'b0);
      expectWr(8'hA1);
      sendByte(8'hA1);
      expectWr(8'hA2);
      sendByte(8'hA2);
      expectWr(8'hA3);
      sendByte(8'hA3);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      sendAbort();
      sendReadDone();
      tick();
      checkOutput("t2_ready_low", {31'd0, Rx_Ready}, 32'd0);

      // 3: 133 bytes into a 128-byte frame
      $display("[TB] test 3: overflow");
      sendFlag(1'b0);
      for (int i = 1; i <= 133; i++) begin
         if (i <= 128) expectWr(8'(i));
         else if (i == 129) expectEvent(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
         sendByte(8'(i));
      end
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd126);
      sendFlag(1'b0);
      tick();
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      sendDrop();
      tick();

      // 4: runts (1 and 2 bytes) and an FCS error
      $display("[TB] test 4: runt and FCS error");
      sendFlag(1'b0);
      expectWr(8'h5A);
      sendByte(8'h5A);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
      sendFlag(1'b0);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      sendReadDone();
      sendFlag(1'b0);
      expectWr(8'h01);
      sendByte(8'h01);
      expectWr(8'h02);
      sendByte(8'h02);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
      sendFlag(1'b0);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      sendReadDone();
      sendFlag(1'b0);
      for (int i = 1; i <= 6; i++) begin
         expectWr(8'(8'hC0 + i));
         sendByte(8'(8'hC0 + i));
      end
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd4);
      sendFlag(1'b1);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      sendReadDone();
      tick();

      // 5: idle flags then abort are silent; abort beats flag in the same cycle
      $display("[TB] test 5: idle flags and abort priority");
      sendFlag(1'b0);
      sendFlag(1'b0);
      sendFlag(1'b0);
      sendAbort();
      tick();
      sendFlag(1'b0);
      expectWr(8'h77);
      sendByte(8'h77);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();

      // 6: disable mid-frame, held frame survives disable, reset clears it
      $display("[TB] test 6: disable and reset");
      sendFlag(1'b0);
      expectWr(8'h31);
      sendByte(8'h31);
      expectWr(8'h32);
      sendByte(8'h32);
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      RxEN = 1'b0;
      tick();
      tick();
      RxEN = 1'b1;
      sendFlag(1'b0);
      for (int i = 1; i <= 6; i++) begin
         expectWr(8'(8'h40 + i));
         sendByte(8'(8'h40 + i));
      end
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd4);
      sendFlag(1'b0);
      RxEN = 1'b0;
      tick();
      tick();
      checkOutput("t6_ready_survives_disable", {31'd0, Rx_Ready}, 32'd1);
      RxEN = 1'b1;
      expectEvent(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      checkOutput("t6_rst_size", {24'd0, Rx_FrameSize}, 32'd0);
      checkOutput("t6_rst_err", {31'd0, Rx_FrameError}, 32'd0);
      checkOutput("t6_rst_data", {24'd0, Rx_DataBuff}, 32'd0);
      tick();
      tick();

      checkOutput("pending_records", expQ.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
